cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 170 +++++++++++++++++
 tb/tb_cordic_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Two-requester CORDIC vectoring scheduler.
// A round-robin arbiter hands one job at a time to a single iterative CORDIC
// engine; the engine returns the raw magnitude (with CORDIC gain) and the
// accumulated angle, held until the consumer takes it.
module cordic_sched #(
   parameter int ITERS = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic        [1:0]  req_valid,
   output logic        [1:0]  req_ready,
   input  logic signed [11:0] req_x0,
   input  logic signed [11:0] req_y0,
   input  logic signed [11:0] req_x1,
   input  logic signed [11:0] req_y1,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_id,
   output logic        [15:0] out_r,
   output logic        [11:0] out_t,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the final micro-rotation; the step at this index ends the job.
   localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

   state_t             state_q, state_d;
   logic        [3:0]  iter_q, iter_d;
   logic signed [15:0] x_q, x_d;
   logic signed [15:0] y_q, y_d;
   logic        [11:0] t_q, t_d;
   logic               id_q, id_d;
   logic               ptr_q, ptr_d;

   logic        [1:0]  grant;
   logic               accept;
   logic               accept_id;
   logic signed [11:0] sel_x;
   logic signed [11:0] sel_y;
   logic signed [15:0] neg_x;
   logic signed [15:0] neg_y;
   logic signed [15:0] x_pos_inc;
   logic signed [15:0] y_pos_inc;
   logic signed [15:0] x_neg_inc;
   logic signed [15:0] y_neg_inc;
   logic        [11:0] t_step;

   // Round-robin grant: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Ready is offered only while idle and out of reset, so it is one-hot or zero.
   always_comb begin
      req_ready = 2'b00;
      if ((state_q == IDLE) && rst_n) begin
         req_ready = grant;
      end
   end

   // Handshake decode and operand selection for the winning requester.
   always_comb begin
      accept    = |(req_valid & req_ready);
      accept_id = req_ready[1];
      sel_x     = accept_id ? req_x1 : req_x0;
      sel_y     = accept_id ? req_y1 : req_y0;
   end

   // Micro-rotation terms: negate first, then shift arithmetically, all from pre-step x/y.
   always_comb begin
      neg_x     = -x_q;
      neg_y     = -y_q;
      x_pos_inc = y_q >>> iter_q;
      y_pos_inc = neg_x >>> iter_q;
      x_neg_inc = neg_y >>> iter_q;
      y_neg_inc = x_q >>> iter_q;
      t_step    = 12'h800 >> iter_q;
   end

   // Next-state and datapath update for the three-state job sequencer.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      x_d     = x_q;
      y_d     = y_q;
      t_d     = t_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               x_d     = {sel_x, 4'b0000};
               y_d     = {sel_y, 4'b0000};
               t_d     = 12'h000;
               iter_d  = 4'd0;
               id_d    = accept_id;
               ptr_d   = ~accept_id;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!y_q[15]) begin
               x_d = x_q + x_pos_inc;
               y_d = y_q + y_pos_inc;
               t_d = t_q + t_step;
            end else begin
               x_d = x_q + x_neg_inc;
               y_d = y_q + y_neg_inc;
               t_d = t_q - t_step;
            end
            if (iter_q == LAST_ITER) begin
               state_d = DONE;
            end else begin
               iter_d = iter_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset discards any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         iter_q  <= 4'd0;
         x_q     <= 16'sd0;
         y_q     <= 16'sd0;
         t_q     <= 12'h000;
         id_q    <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         x_q     <= x_d;
         y_q     <= y_d;
         t_q     <= t_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   // Result presentation: data is forced to zero whenever no result is offered.
   always_comb begin
      out_valid = (state_q == DONE);
      out_id    = id_q;
      out_r     = out_valid ? x_q : 16'h0000;
      out_t     = out_valid ? t_q : 12'h000;
      busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched: a bus monitor models the arbiter,
// queues golden results at acceptance and compares them at output handshake.
module tb_cordic_sched;

   logic               clk;
   logic               rst_n;
   logic        [1:0]  req_valid;
   logic        [1:0]  req_ready;
   logic signed [11:0] req_x0, req_y0, req_x1, req_y1;
   logic               out_valid;
   logic               out_ready;
   logic               out_id;
   logic        [15:0] out_r;
   logic        [11:0] out_t;
   logic               busy;

   logic        [1:0]  req_valid4;
   logic        [1:0]  req_ready4;
   logic               out_valid4;
   logic               out_id4;
   logic        [15:0] out_r4;
   logic        [11:0] out_t4;
   logic               busy4;

   typedef struct {
      logic        id;
      logic [15:0] r;
      logic [11:0] t;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycle       = 0;
   int   accept_cycle = 0;
   int   accept_count = 0;
   logic grant_ids[$];
   logic mptr  = 1'b0;
   logic mbusy = 1'b0;
   logic prev_valid = 1'b0;

   cordic_sched #(.ITERS(12)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_r(out_r), .out_t(out_t), .busy(busy)
   );

   cordic_sched #(.ITERS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_x0(12'sd0), .req_y0(12'sd0), .req_x1(12'sd0), .req_y1(12'sd0),
      .out_valid(out_valid4), .out_ready(1'b1), .out_id(out_id4),
      .out_r(out_r4), .out_t(out_t4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bit-exact golden CORDIC vectoring model.
   function automatic logic [27:0] cordicModel(input logic signed [11:0] xi,
                                               input logic signed [11:0] yi,
                                               input int iters);
      logic signed [15:0] x, y, nx, ny, mx, my;
      logic        [11:0] t;
      x = {xi, 4'b0000};
      y = {yi, 4'b0000};
      t = 12'h000;
      for (int i = 0; i < iters; i++) begin
         mx = -x;
         my = -y;
         if (y >= 0) begin
            nx = x + (y >>> i);
            ny = y + (mx >>> i);
            t  = t + (12'd1 << (11 - i));
         end else begin
            nx = x + (my >>> i);
            ny = y + (x >>> i);
            t  = t - (12'd1 << (11 - i));
         end
         x = nx;
         y = ny;
      end
      return {x, t};
   endfunction

   // Bus monitor: arbiter model, ready check, latency check and scoreboard.
   always @(negedge clk) begin
      logic [1:0]  exp_ready;
      logic [27:0] res;
      exp_t        e;
      if (!rst_n) begin
         mptr  = 1'b0;
         mbusy = 1'b0;
         prev_valid = 1'b0;
         sb.delete();
         checkOutput("rst_ready", {30'd0, req_ready}, 32'd0);
         checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      end else begin
         exp_ready = 2'b00;
         if (!mbusy) begin
            case (req_valid)
               2'b01:   exp_ready = 2'b01;
               2'b10:   exp_ready = 2'b10;
               2'b11:   exp_ready = mptr ? 2'b10 : 2'b01;
               default: exp_ready = 2'b00;
            endcase
         end
         checkOutput("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
         checkOutput("busy", {31'd0, busy}, {31'd0, mbusy});
         if (out_valid && !prev_valid) begin
            checkOutput("latency", cycle - accept_cycle, 32'd12);
         end
         if (!out_valid) begin
            checkOutput("idle_r", {16'd0, out_r}, 32'd0);
            checkOutput("idle_t", {20'd0, out_t}, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("sb_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("out_id", {31'd0, out_id}, {31'd0, e.id});
               checkOutput("out_r", {16'd0, out_r}, {16'd0, e.r});
               checkOutput("out_t", {20'd0, out_t}, {20'd0, e.t});
            end
            mbusy = 1'b0;
         end
         if (exp_ready != 2'b00) begin
            e.id = exp_ready[1];
            res  = exp_ready[1] ? cordicModel(req_x1, req_y1, 12) : cordicModel(req_x0, req_y0, 12);
            e.r  = res[27:12];
            e.t  = res[11:0];
            sb.push_back(e);
            grant_ids.push_back(exp_ready[1]);
            mptr  = ~exp_ready[1];
            mbusy = 1'b1;
            accept_cycle = cycle + 1;
            accept_count++;
         end
         prev_valid = out_valid;
      end
   end

   task automatic waitAccept(input int target);
      int n = 0;
      while (accept_count < target && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (accept_count < target) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitOutValid();
      int n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (!out_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((sb.size() != 0 || mbusy) && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (sb.size() != 0 || mbusy) checkOutput("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   // Drive one job, drop the request after acceptance and scramble operands.
   task automatic applyStimulus(input logic [1:0] mask,
                                input logic signed [11:0] x0, input logic signed [11:0] y0,
                                input logic signed [11:0] x1, input logic signed [11:0] y1);
      int target;
      @(posedge clk); #2;
      req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1;
      req_valid = mask;
      target = accept_count + 1;
      waitAccept(target);
      req_valid = 2'b00;
      req_x0 = 12'($urandom); req_y0 = 12'($urandom);
      req_x1 = 12'($urandom); req_y1 = 12'($urandom);
   endtask

   initial begin
      logic signed [11:0] ex[4];
      logic signed [11:0] ey[4];
      int target;
      int acc4;
      int n;

      ex[0] = -12'sd2048; ey[0] =  12'sd2047;
      ex[1] =  12'sd2047; ey[1] = -12'sd2048;
      ex[2] =  12'sd2047; ey[2] =  12'sd2047;
      ex[3] = -12'sd2048; ey[3] = -12'sd2048;

      rst_n = 1'b0;
      req_valid = 2'b11;
      req_valid4 = 2'b00;
      out_ready = 1'b1;
      req_x0 = 12'sd5; req_y0 = 12'sd7; req_x1 = 12'sd9; req_y1 = 12'sd3;

      // Outputs during reset before any clock edge.
      #3;
      checkOutput("reset_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_r", {16'd0, out_r}, 32'd0);
      checkOutput("reset_t", {20'd0, out_t}, 32'd0);
      checkOutput("reset_id", {31'd0, out_id}, 32'd0);
      @(negedge clk);
      @(posedge clk); #2;
      req_valid = 2'b00;
      rst_n = 1'b1;

      // Zero operand on requester 0.
      applyStimulus(2'b01, 12'sd0, 12'sd0, 12'sd100, 12'sd100);
      waitOutValid();
      checkOutput("zero_r", {16'd0, out_r}, 32'h0000);
      checkOutput("zero_t", {20'd0, out_t}, 32'h0FFF);
      checkOutput("zero_id", {31'd0, out_id}, 32'd0);
      waitDrain();

      // Both requesters from reset: grant 0 then 1.
      doReset();
      grant_ids.delete();
      req_x0 = 12'sd300; req_y0 = -12'sd200; req_x1 = -12'sd50; req_y1 = 12'sd900;
      req_valid = 2'b11;
      target = accept_count + 2;
      waitAccept(target);
      req_valid = 2'b00;
      waitDrain();
      checkOutput("rr_count", grant_ids.size(), 32'd2);
      if (grant_ids.size() >= 2) begin
         checkOutput("rr_first", {31'd0, grant_ids[0]}, 32'd0);
         checkOutput("rr_second", {31'd0, grant_ids[1]}, 32'd1);
      end

      // Corner and random operands through the scoreboard.
      for (int k = 0; k < 24; k++) begin
         if (k < 4) begin
            applyStimulus(k[0] ? 2'b10 : 2'b01, ex[k], ey[k], ex[k], ey[k]);
         end else begin
            applyStimulus(2'($urandom_range(1, 3)), 12'($urandom), 12'($urandom),
                          12'($urandom), 12'($urandom));
         end
         waitDrain();
      end

      // Consumer stalls for 20 cycles with a request pending.
      @(posedge clk); #2;
      out_ready = 1'b0;
      req_x0 = -12'sd700; req_y0 = 12'sd1234;
      req_valid = 2'b01;
      target = accept_count + 1;
      waitAccept(target);
      req_valid = 2'b11;
      waitOutValid();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checkOutput("hold_sb", 32'd0, 32'd1);
         end else begin
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_r", {16'd0, out_r}, {16'd0, sb[0].r});
            checkOutput("hold_t", {20'd0, out_t}, {20'd0, sb[0].t});
            checkOutput("hold_id", {31'd0, out_id}, {31'd0, sb[0].id});
            checkOutput("hold_ready", {30'd0, req_ready}, 32'd0);
         end
      end
      @(posedge clk); #2;
      out_ready = 1'b1;
      target = accept_count + 1;
      @(posedge clk); #2;
      checkOutput("hold_release_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("hold_release_busy", {31'd0, busy}, 32'd0);
      waitAccept(target);
      req_valid = 2'b00;
      waitDrain();

      // Reset in the middle of a job, then rerun it cleanly.
      applyStimulus(2'b10, 12'sd0, 12'sd0, 12'sd1500, -12'sd321);
      repeat (5) @(posedge clk);
      #2;
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_r", {16'd0, out_r}, 32'd0);
      checkOutput("midrst_t", {20'd0, out_t}, 32'd0);
      checkOutput("midrst_id", {31'd0, out_id}, 32'd0);
      checkOutput("midrst_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      @(posedge clk); #2;
      req_valid = 2'b00;
      rst_n = 1'b1;
      applyStimulus(2'b10, 12'sd0, 12'sd0, 12'sd1500, -12'sd321);
      waitDrain();

      // Four-iteration instance with a zero operand.
      @(posedge clk); #2;
      req_valid4 = 2'b01;
      @(negedge clk);
      checkOutput("it4_ready", {30'd0, req_ready4}, 32'd1);
      acc4 = cycle + 1;
      @(posedge clk); #2;
      req_valid4 = 2'b00;
      n = 0;
      while (!out_valid4 && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput("it4_valid", {31'd0, out_valid4}, 32'd1);
      checkOutput("it4_latency", cycle - acc4, 32'd4);
      checkOutput("it4_t", {20'd0, out_t4}, 32'h0F00);
      checkOutput("it4_r", {16'd0, out_r4}, 32'h0000);
      checkOutput("it4_id", {31'd0, out_id4}, 32'd0);
      @(posedge clk); #2;
      checkOutput("it4_busy", {31'd0, busy4}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
